// File: rtl/adxl_spi_sampler.sv
// ADXL345 front end: configures the sensor over SPI mode 3, then reads one axis
// every SAMPLE_PERIOD clocks and presents it as a signed word with a one-cycle strobe.
module adxl_spi_sampler #(
  parameter int CLK_DIV       = 25,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int AXIS          = 0,
  parameter int A_DATA_WIDTH  = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           spi_sclk,
  output logic                           spi_cs_n,
  output logic                           spi_mosi,
  input  logic                           spi_miso,
  output logic signed [A_DATA_WIDTH-1:0] accelerometer_data,
  output logic                           sample_valid,
  output logic                           init_done,
  output logic                           overrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [7:0] AXIS_REG = 8'(8'h32 + 2 * AXIS);
  localparam logic [7:0] READ_CMD = 8'hC0 | AXIS_REG;

  typedef enum logic [1:0] {INIT_FMT, INIT_PWR, WAIT_TICK, READ} seq_t;
  typedef enum logic [2:0] {IDLE, SETUP, CLK_LO, CLK_HI, HOLD, GAP} eng_t;

  seq_t             seq_q, seq_d;
  eng_t             eng_q, eng_d;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bits_left;
  logic [4:0]       bits_load;
  logic [23:0]      tx_sh;
  logic [23:0]      tx_load;
  logic [15:0]      rx_sh;
  logic [TMR_W-1:0] timer;
  logic             start;
  logic             phase_end;
  logic             frame_done;
  logic             tick;
  logic signed [15:0]              raw_word;
  logic signed [A_DATA_WIDTH-1:0]  sample_word;

  assign phase_end  = (div_cnt == DIV_LAST);
  assign frame_done = (eng_q == GAP) && phase_end;
  assign tick       = init_done && (timer == TMR_LAST);

  // MISO bytes arrive low then high, so after the last bit the high byte sits in [7:0].
  assign raw_word = {rx_sh[7:0], rx_sh[15:8]};

  generate
    if (A_DATA_WIDTH == 16) begin : g_same
      assign sample_word = raw_word;
    end else if (A_DATA_WIDTH > 16) begin : g_ext
      assign sample_word = {{(A_DATA_WIDTH - 16){raw_word[15]}}, raw_word};
    end else begin : g_trunc
      assign sample_word = raw_word[15 -: A_DATA_WIDTH];
    end
  endgenerate

  // Sequencer: picks the next transaction and launches the engine.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    seq_d     = seq_q;
    start     = 1'b0;
    tx_load   = {READ_CMD, 16'h0000};
    bits_load = 5'd24;
    case (seq_q)
      INIT_FMT: begin
        start     = (eng_q == IDLE);
        tx_load   = {8'h31, 8'h0B, 8'h00};
        bits_load = 5'd16;
        if (frame_done) seq_d = INIT_PWR;
      end
      INIT_PWR: begin
        start     = (eng_q == IDLE);
        tx_load   = {8'h2D, 8'h08, 8'h00};
        bits_load = 5'd16;
        if (frame_done) seq_d = WAIT_TICK;
      end
      WAIT_TICK: begin
        if (tick) begin
          start = 1'b1;
          seq_d = READ;
        end
      end
      READ: begin
        if (frame_done) seq_d = WAIT_TICK;
      end
      default: seq_d = INIT_FMT;
    endcase
  end

  always_comb begin
    eng_d = eng_q;
    case (eng_q)
      IDLE:    if (start)     eng_d = SETUP;
      SETUP:   if (phase_end) eng_d = CLK_LO;
      CLK_LO:  if (phase_end) eng_d = CLK_HI;
      CLK_HI:  if (phase_end) eng_d = (bits_left == 5'd1) ? HOLD : CLK_LO;
      HOLD:    if (phase_end) eng_d = GAP;
      GAP:     if (phase_end) eng_d = IDLE;
      default: eng_d = IDLE;
    endcase
  end

  // SPI pins are registered from the next state so they are glitch-free and
  // still fall back to idle levels the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_q     <= IDLE;
      div_cnt   <= '0;
      bits_left <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      spi_sclk  <= 1'b1;
      spi_cs_n  <= 1'b1;
      spi_mosi  <= 1'b0;
    end else begin
      eng_q    <= eng_d;
      div_cnt  <= (eng_d != eng_q || eng_q == IDLE) ? '0 : div_cnt + DIV_W'(1);
      spi_sclk <= (eng_d != CLK_LO);
      spi_cs_n <= !(eng_d inside {SETUP, CLK_LO, CLK_HI, HOLD});
      if (start) begin
        tx_sh     <= tx_load;
        bits_left <= bits_load;
      end else if (eng_q != CLK_LO && eng_d == CLK_LO) begin
        spi_mosi <= tx_sh[23];
        tx_sh    <= {tx_sh[22:0], 1'b0};
      end
      if (eng_q == CLK_HI && phase_end) bits_left <= bits_left - 5'd1;
      if (eng_q == CLK_HI && div_cnt == '0) rx_sh <= {rx_sh[14:0], spi_miso};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q              <= INIT_FMT;
      init_done          <= 1'b0;
      overrun            <= 1'b0;
      timer              <= '0;
      sample_valid       <= 1'b0;
      accelerometer_data <= '0;
    end else begin
      seq_q        <= seq_d;
      sample_valid <= 1'b0;
      if (seq_q == INIT_PWR && frame_done) begin
        init_done <= 1'b1;
        timer     <= '0;
      end else if (init_done) begin
        timer <= (timer == TMR_LAST) ? '0 : timer + TMR_W'(1);
      end
      // Ticks landing while a read (including its gap) is in flight are dropped, not queued.
      if (tick && seq_q == READ) overrun <= 1'b1;
      if (seq_q == READ && eng_q == HOLD && phase_end) begin
        sample_valid       <= 1'b1;
        accelerometer_data <= sample_word;
      end
    end
  end

endmodule

// File: doc/adxl_spi_sampler.md
# adxl_spi_sampler

- Upstream stage of the accelerometer FIR filter.
- Configures an ADXL345 accelerometer over 4-wire SPI (mode 3), then reads one 16-bit axis at a fixed sample rate.
- Each result is presented as a signed word with a one-cycle `sample_valid` strobe, which connects directly to the filter's `accelerometer_data`/`sample_valid` inputs.

## Interface
Parameters:
- `CLK_DIV`, 25: clk cycles per SCLK half-period (50 MHz gives 1 MHz SCLK); must be ≥ 2.
- `SAMPLE_PERIOD`, 50000: clk cycles between sample ticks; legal when greater than 51·CLK_DIV.
- `AXIS`, 0: axis select; 0 = X (reg 0x32), 1 = Y (0x34), 2 = Z (0x36).
- `A_DATA_WIDTH`, 16: output sample width.

Ports:
- `clk`  in  1  system clock; the block uses one clock only.
- `rst`  in  1  asynchronous, active-high reset.
- `spi_sclk`  out  1  SPI clock; idles high.
- `spi_cs_n`  out  1  chip select, active low.
- `spi_mosi`  out  1  master data out.
- `spi_miso`  in  1  slave data in.
- `accelerometer_data`  out  A_DATA_WIDTH, signed  last sample read.
- `sample_valid`  out  1  one-cycle strobe; `accelerometer_data` is new in this cycle.
- `init_done`  out  1  high once the configuration writes have completed.
- `overrun`  out  1  sticky flag; a sample tick was dropped because a read was still in progress.

## Operation
- Reset values: `spi_sclk`=1, `spi_cs_n`=1, `spi_mosi`=0, `accelerometer_data`=0, `sample_valid`=0, `init_done`=0, `overrun`=0. All FSMs return to INIT_FMT/IDLE.
- Sequencer states, in order:
  - INIT_FMT: write reg 0x31 = 0x0B (full resolution, ±16 g, 4-wire).
  - INIT_PWR: write reg 0x2D = 0x08 (measure).
  - WAIT_TICK.
  - READ: multi-byte read; command byte 0xC0|addr, then 2 data bytes.
- Write transaction: 16 bits; command byte = register address with R=0, MB=0, followed by the data byte.
- Read transaction: 24 bits. MISO bytes arrive low byte then high byte.
  - `accelerometer_data` = {high, low}, interpreted as signed.
  - For A_DATA_WIDTH ≠ 16, sign-extend or truncate the LSBs.
- SPI engine states:
  - IDLE.
  - SETUP: CS_N low, SCLK high, for CLK_DIV cycles.
  - CLK_LO: SCLK low for CLK_DIV cycles. MOSI updates on entry, MSB first.
  - CLK_HI: SCLK high for CLK_DIV cycles. MISO is sampled on the first clk cycle of CLK_HI, i.e. at the rising edge.
  - HOLD: SCLK high, CS_N low, for CLK_DIV cycles.
  - GAP: CS_N high for CLK_DIV cycles.
  - Then back to IDLE.
- Sample timer:
  - Cleared to 0 on the cycle `init_done` rises.
  - Counts 0..SAMPLE_PERIOD-1 and wraps; a tick fires at SAMPLE_PERIOD-1.
  - A tick in WAIT_TICK starts READ on the next cycle.
  - A tick in READ, or during its GAP, is dropped and sets `overrun`. It is not queued.
- `sample_valid` pulses for exactly one cycle: the cycle CS_N rises at the end of the READ HOLD. `accelerometer_data` updates in that same cycle and holds until the next valid.
- Write transactions never produce `sample_valid`.

## Timing
- Transaction duration, CS_N low: (2·bits + 2)·CLK_DIV cycles.
  - Write: 34·CLK_DIV.
  - Read: 50·CLK_DIV.
  - Each is followed by a CLK_DIV-cycle GAP.
- `init_done` rises the cycle after INIT_PWR's GAP ends, i.e. 70·CLK_DIV + 2 cycles (±2) after `rst` deasserts.
- In steady state, `sample_valid` has period exactly SAMPLE_PERIOD.
- Latency from tick to `sample_valid`: 1 + 50·CLK_DIV cycles.
- MOSI is stable for a full half-period before every SCLK rise. CS_N never toggles while SCLK is low.
- Reset mid-transaction:
  - Outputs go to reset values immediately (asynchronous): CS_N high, SCLK high.
  - No `sample_valid` is produced.
  - After release, the init sequence restarts from INIT_FMT.

## Test plan
- Init: CLK_DIV=2, SPI slave model. Release reset → first CS_N frame carries MOSI 0x31,0x0B; second frame carries 0x2D,0x08. CS_N is high ≥2 cycles between frames. `init_done`=1 after the second GAP, and `sample_valid` never asserted during init.
- Read: AXIS=0, slave returns low byte 0x34 then high byte 0xFF → MOSI command byte 0xF2. `accelerometer_data`=0xFF34 (−204) with a single one-cycle `sample_valid` at CS_N rise. Repeat with 0x00,0x7F → +32512.
- Periodic: CLK_DIV=2, SAMPLE_PERIOD=200 → consecutive `sample_valid` pulses exactly 200 cycles apart; `overrun` stays 0.
- Overrun: CLK_DIV=2, SAMPLE_PERIOD=60 (read frame = 102 cycles) → `overrun` goes to 1 and stays 1; `sample_valid` pulses 120 cycles apart.
- Reset mid-read: assert `rst` during the 10th read bit → same cycle: `spi_cs_n`=1, `spi_sclk`=1, `init_done`=0, `overrun`=0. No `sample_valid`. After release, MOSI again shows 0x31,0x0B first.
- Axis select: AXIS=2 → read command byte 0xF6; AXIS=1 → 0xF4.
